// File: rtl/serial_sub16.sv
// Bit-serial signed subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop walk the operand shift
// registers. The result is committed to the output registers only on the
// final bit, so partial results are never visible.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, accepted when not busy (in idle or on the done cycle)
//   a, b   - minuend / subtrahend, captured on the accepting edge only
//   diff   - registered a - b mod 2^WIDTH
//   borrow - unsigned(a) < unsigned(b)
//   ovf    - signed overflow of the subtraction
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when diff/borrow/ovf are updated
module serial_sub16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;

    // Full-subtractor cell on the current LSBs.
    logic a_bit, b_bit, d_bit, br_next, last_bit;

    assign a_bit    = a_sr_q[0];
    assign b_bit    = b_sr_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    br_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRun: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = {d_bit, res_sr_q[WIDTH-1:1]};
                br_d     = br_next;
                cnt_d    = cnt_q + CntW'(1);
                if (last_bit) begin
                    // On the last bit the operand LSBs are the original sign bits.
                    diff_d   = {d_bit, res_sr_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    ovf_d    = (a_bit ^ b_bit) & (d_bit ^ a_bit);
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_serial_sub16.sv
module tb_serial_sub16;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  diff;
    logic          borrow;
    logic          ovf;
    logic          busy;
    logic          done;

    int total;
    int bad;
    logic [W-1:0] prev_diff;

    serial_sub16 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start high and let the accepting edge pass.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input bit hold);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Called on the first negedge after the accepting edge.
    task automatic wait_done(input string tag, input logic [W-1:0] ed, input logic eb,
                             input logic eo, input bit hold);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " hold"}, 32'(diff), 32'(prev_diff));
            if (hold) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(W));
        check({tag, " diff"}, 32'(diff), 32'(ed));
        check({tag, " borrow"}, 32'(borrow), 32'(eb));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        prev_diff = ed;
        if (!hold) begin
            @(negedge clk);
            check({tag, " done_pulse"}, 32'(done), 32'd0);
            check({tag, " idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] va, vb, ed;
        logic eb, eo;
        int dn;
        total = 0;
        bad = 0;
        prev_diff = '0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst diff", 32'(diff), 32'd0);
        check("rst flags", {29'd0, borrow, ovf, busy}, 32'd0);
        check("rst done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'd17, 16'd54, 1'b0);
        wait_done("t17_54", 16'hFFDB, 1'b1, 1'b0, 1'b0);
        launch(16'd11, 16'd37, 1'b0);
        wait_done("t11_37", 16'hFFE6, 1'b1, 1'b0, 1'b0);
        launch(16'd27, 16'hFFF2, 1'b0);
        wait_done("t27_m14", 16'd41, 1'b1, 1'b0, 1'b0);
        launch(16'h7FFF, 16'hFFFF, 1'b0);
        wait_done("tmax_m1", 16'h8000, 1'b1, 1'b1, 1'b0);
        launch(16'h8000, 16'h0001, 1'b0);
        wait_done("tmin_1", 16'h7FFF, 1'b0, 1'b1, 1'b0);
        launch(16'hFFFB, 16'hFFFB, 1'b0);
        wait_done("tm5_m5", 16'h0000, 1'b0, 1'b0, 1'b0);

        // start held high with operands toggling; back-to-back requests.
        launch(16'd100, 16'd40, 1'b1);
        wait_done("held1", 16'd60, 1'b0, 1'b0, 1'b1);
        launch(16'd500, 16'd700, 1'b1);
        wait_done("held2", 16'hFF38, 1'b1, 1'b0, 1'b1);
        launch(16'd5, 16'd2, 1'b0);
        wait_done("held3", 16'd3, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run.
        launch(16'd1000, 16'd3, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async diff", 32'(diff), 32'd0);
        check("async flags", {29'd0, borrow, ovf, busy}, 32'd0);
        check("async done", 32'(done), 32'd0);
        prev_diff = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("no done after abort", 32'(dn), 32'd0);

        // Release reset with start already high.
        rst_n = 1'b0;
        a = 16'd1000;
        b = 16'd3;
        start = 1'b1;
        #2 rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("post_rst", 16'd997, 1'b0, 1'b0, 1'b0);

        // Random vectors against a combinational reference.
        for (int i = 0; i < 1000; i++) begin
            bit hold;
            hold = (i % 2 == 1) && (i != 999);
            va = W'($urandom);
            vb = W'($urandom);
            ed = va - vb;
            eb = (va < vb);
            eo = (va[W-1] != vb[W-1]) && (ed[W-1] != va[W-1]);
            launch(va, vb, hold);
            wait_done("rand", ed, eb, eo, hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub16.md
Name: serial_sub16

Overview:
- Bit-serial signed subtractor: the subtract-direction counterpart of the existing combinational 16-bit adder.
- Computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Produces unsigned borrow and signed overflow flags.
- Uses a start/busy/done handshake so it can sit behind a controller in area-constrained datapaths.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement); must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising clk edge, accepted only when busy=0
- a  input  WIDTH  minuend, signed; captured on the accepting edge only
- b  input  WIDTH  subtrahend, signed; captured on the accepting edge only
- diff  output  WIDTH  result a - b mod 2^WIDTH, signed, registered
- borrow  output  1  1 when unsigned(a) < unsigned(b)
- ovf  output  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a)
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse marking a new valid diff/borrow/ovf

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk):
  - state=IDLE; diff=0, borrow=0, ovf=0, busy=0, done=0.
  - Internal shift registers, bit counter and borrow flop are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1: capture a, b into shift registers, clear the borrow flop and bit counter, go to RUN. busy=1 after that edge.
  - With start=0: stay in IDLE.
- RUN, one edge per bit:
  - d_i = a_i ^ b_i ^ br.
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d_i into the result shift register from the MSB end; shift the operand registers right.
  - Increment the bit counter.
  - On the edge that processes bit WIDTH-1, in the same edge:
    - Load diff from the completed result.
    - borrow = final br'.
    - ovf from the captured MSBs of a and b and the MSB of the result.
    - done=1, busy=0, go to DONE.
- DONE (one cycle):
  - done=1.
  - Next edge: done=0.
  - If start=1 on that edge, accept a new request exactly as in IDLE (back-to-back operation) and go to RUN; otherwise go to IDLE.
- Latency:
  - Request accepted at edge k.
  - Results and done become visible after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles when start is held high.
- Output holding:
  - diff/borrow/ovf change only on the completion edge or on reset.
  - They hold the previous result throughout a subsequent RUN; no partial results are ever visible.
- Boundary conditions:
  - start high while busy=1 is ignored: no re-capture, no queuing.
  - a and b may change freely after the accepting edge.
  - Wrap-around is modulo 2^WIDTH; no saturation.
  - Reset asserted mid-RUN aborts the operation, returns all outputs to reset values, and no done pulse is issued.
  - Reset released with start=1: the request is accepted on the first rising edge after deassertion.

Test Plan:
- Reset, then a=17, b=54, start pulse -> busy=1 for 16 cycles; done pulse after edge k+16 with diff=-37, borrow=1, ovf=0.
- a=11, b=37 -> diff=-26, borrow=1, ovf=0. Then a=27, b=-14 -> diff=41, borrow=1 (27 < 65522 unsigned), ovf=0. Check diff holds -26 throughout the second RUN until its completion edge.
- Overflow cases:
  - a=32767, b=-1 -> diff=-32768, ovf=1, borrow=1.
  - a=-32768, b=1 -> diff=32767, ovf=1, borrow=0.
  - a=b=-5 -> diff=0, ovf=0, borrow=0.
- start held high with a/b toggled every cycle during RUN -> only the values at the accepting edge are used (a=100, b=40 -> diff=60). Back-to-back: the second request is accepted on the edge leaving DONE, so done pulses every 17 cycles.
- rst_n pulled low asynchronously (between clk edges) at bit 7 of a=1000, b=3 -> all outputs 0 immediately and no done pulse. After release, a fresh start gives diff=997, borrow=0, ovf=0.
- Randomised 1000 vectors compared against the combinational a-b reference model (diff, borrow, ovf); every start asserted while busy=1 is checked to be ignored.
